delaychain_probe: RTL and testbench

- Measurement end of the delay-chain test path. Launches a single transition into a chain input.
- Waits for the transition to return on the chain output, synchronized into clk, and counts the round-trip in clk cycles.
- Keeps min/max/count statistics across runs so that chain delay and its variation can be read back from the tile pins.

---
 rtl/delaychain_probe.sv | 106 ++++++++++
 tb/tb_delaychain_probe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/delaychain_probe.sv
// delaychain_probe: launches a transition into a delay chain and measures its synchronized round-trip in clk cycles.
// Keeps min/max/count statistics across successful runs; aborts with a sticky error on timeout.
module delaychain_probe #(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 65535,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_stats,
    input  logic             echo,
    output logic             launch,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             err,
    output logic [CNT_W-1:0] delay_cnt,
    output logic [CNT_W-1:0] min_cnt,
    output logic [CNT_W-1:0] max_cnt,
    output logic [7:0]       meas_cnt
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ARM  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d, delay_q, delay_d, min_q, min_d, max_q, max_d;
    logic [7:0]             meas_q, meas_d;
    logic                   launch_q, launch_d, done_q, done_d, to_q, to_d, err_q, err_d;
    logic                   matched, at_limit, capture, abort;

    assign matched  = sync_q[SYNC_STAGES-1] == launch_q;
    assign at_limit = cnt_q == CNT_W'(TIMEOUT);
    assign capture  = state_q == WAIT && matched;
    assign abort    = (state_q == ARM || state_q == WAIT) && !matched && at_limit;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        launch_d = launch_q;
        case (state_q)
            IDLE: begin
                state_d = start ? ARM : IDLE;
                cnt_d   = '0;
            end
            ARM: begin
                state_d  = matched ? WAIT : (at_limit ? IDLE : ARM);
                launch_d = matched ? ~launch_q : launch_q;
                cnt_d    = matched ? '0 : cnt_q + CNT_W'(1);
            end
            WAIT: begin
                state_d = (matched || at_limit) ? IDLE : WAIT;
                cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        done_d  = capture;
        to_d    = abort;
        delay_d = capture ? cnt_q : (abort ? '1 : delay_q);
        // A clear coinciding with a capture wins: the sample is dropped from the stats.
        min_d   = clr_stats ? '1 : (capture && cnt_q < min_q ? cnt_q : min_q);
        max_d   = clr_stats ? '0 : (capture && cnt_q > max_q ? cnt_q : max_q);
        meas_d  = clr_stats ? '0 : (capture && meas_q != 8'hFF ? meas_q + 8'd1 : meas_q);
        err_d   = clr_stats ? 1'b0 : (abort | err_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            cnt_q    <= '0;
            launch_q <= 1'b0;
            done_q   <= 1'b0;
            to_q     <= 1'b0;
            err_q    <= 1'b0;
            delay_q  <= '0;
            min_q    <= '1;
            max_q    <= '0;
            meas_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[SYNC_STAGES-2:0], echo};
            cnt_q    <= cnt_d;
            launch_q <= launch_d;
            done_q   <= done_d;
            to_q     <= to_d;
            err_q    <= err_d;
            delay_q  <= delay_d;
            min_q    <= min_d;
            max_q    <= max_d;
            meas_q   <= meas_d;
        end
    end

    assign launch    = launch_q;
    assign busy      = state_q != IDLE;
    assign done      = done_q;
    assign timeout   = to_q;
    assign err       = err_q;
    assign delay_cnt = delay_q;
    assign min_cnt   = min_q;
    assign max_cnt   = max_q;
    assign meas_cnt  = meas_q;
endmodule

// File: tb/tb_delaychain_probe.sv
// tb_delaychain_probe: randomized delay-chain runs scored against a per-run behavioural model.
module tb_delaychain_probe;
    localparam int TO = 20;
    localparam int SYNC = 2;

    typedef struct {
        bit          to;
        logic [15:0] dly;
        logic [15:0] mn;
        logic [15:0] mx;
        logic [7:0]  ms;
        bit          er;
        bit          ln;
        int          bz;
    } exp_t;

    logic        clk = 0, rst = 1, start = 0, clr_stats = 0, echo;
    logic        launch, busy, done, timeout, err;
    logic [15:0] delay_cnt, min_cnt, max_cnt;
    logic [7:0]  meas_cnt;

    int          vectors = 0, miscompares = 0;
    exp_t        sb[$];
    int          dsel = 0;
    bit          stuck_en = 0, stuck_val = 0;
    logic [31:0] line_q = '0;
    int          busy_n = 0;

    bit          m_l = 0, m_err = 0;
    logic [15:0] m_min = 16'hFFFF, m_max = 16'h0;
    logic [7:0]  m_meas = 8'd0;

    delaychain_probe #(.CNT_W(16), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .start(start), .clr_stats(clr_stats), .echo(echo),
        .launch(launch), .busy(busy), .done(done), .timeout(timeout), .err(err),
        .delay_cnt(delay_cnt), .min_cnt(min_cnt), .max_cnt(max_cnt), .meas_cnt(meas_cnt)
    );

    always #5 clk = ~clk;

    // External chain: a D-cycle register delay of launch, or a stuck level.
    always @(posedge clk) line_q <= {line_q[30:0], launch};
    assign echo = stuck_en ? stuck_val : (dsel == 0 ? launch : line_q[dsel-1]);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) busy_n = 0;
        else begin
            if (busy) busy_n++;
            if (done || timeout) begin
                exp_t e;
                check("done_and_timeout_exclusive", {31'd0, done & timeout}, 0);
                check("busy_low_on_pulse", {31'd0, busy}, 0);
                if (sb.size() == 0) check("unexpected_pulse", 1, 0);
                else begin
                    e = sb.pop_front();
                    check("pulse_kind_timeout", {31'd0, timeout}, {31'd0, e.to});
                    check("delay_cnt", {16'd0, delay_cnt}, {16'd0, e.dly});
                    check("min_cnt", {16'd0, min_cnt}, {16'd0, e.mn});
                    check("max_cnt", {16'd0, max_cnt}, {16'd0, e.mx});
                    check("meas_cnt", {24'd0, meas_cnt}, {24'd0, e.ms});
                    check("err", {31'd0, err}, {31'd0, e.er});
                    check("launch", {31'd0, launch}, {31'd0, e.ln});
                    check("busy_cycles", busy_n, e.bz);
                end
                busy_n = 0;
            end
        end
    end

    task automatic model_reset();
        m_l = 0; m_err = 0; m_min = 16'hFFFF; m_max = 0; m_meas = 0;
    endtask

    task automatic run(input int d, input bit clr_cap, input bit dup);
        exp_t e;
        bit ok;
        int k = 0;
        bit seen = 0;
        dsel = d;
        if (stuck_en) begin
            ok = 0;
            if (m_l != stuck_val) e.bz = TO + 1;
            else begin m_l = ~m_l; e.bz = TO + 2; end
        end else begin
            m_l = ~m_l;
            ok = d + SYNC <= TO;
            e.bz = ok ? d + SYNC + 2 : TO + 2;
        end
        if (ok) begin
            e.dly = 16'(d + SYNC);
            if (clr_cap) begin m_min = 16'hFFFF; m_max = 0; m_meas = 0; m_err = 0; end
            else begin
                if (e.dly < m_min) m_min = e.dly;
                if (e.dly > m_max) m_max = e.dly;
                if (m_meas != 8'hFF) m_meas++;
            end
        end else begin
            e.dly = 16'hFFFF;
            m_err = 1;
        end
        e.to = !ok; e.mn = m_min; e.mx = m_max; e.ms = m_meas; e.er = m_err; e.ln = m_l;
        sb.push_back(e);
        @(negedge clk) start = 1;
        @(posedge clk) #1 start = 0;
        if (dup) begin
            @(posedge clk) #1 start = 1;
            @(posedge clk) #1 start = 0;
            k = 2;
        end
        if (clr_cap && ok) begin
            repeat (d + SYNC + 1 - k) @(posedge clk);
            #1 clr_stats = 1;
            @(posedge clk) #1 clr_stats = 0;
        end
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = done | timeout;
        end
        if (!seen) check("run_completion_bound", 0, 1);
        repeat (40) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_launch", {31'd0, launch}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_min", {16'd0, min_cnt}, 32'hFFFF);
        check("rst_max", {16'd0, max_cnt}, 0);
        check("rst_meas", {24'd0, meas_cnt}, 0);
        check("rst_delay", {16'd0, delay_cnt}, 0);
        @(negedge clk) rst = 0;
        repeat (5) @(posedge clk);

        run(0, 0, 0);
        run(5, 0, 0);
        run(5, 0, 0);
        run(3, 0, 0);
        run(9, 0, 0);
        run(5, 0, 0);
        run(TO - SYNC, 0, 0);
        run(TO - SYNC + 1, 0, 0);

        dsel = 0; stuck_en = 1; stuck_val = 0;
        repeat (40) @(posedge clk);
        run(0, 0, 0);
        run(0, 0, 0);
        stuck_en = 0;
        repeat (40) @(posedge clk);

        run(4, 1, 1);
        run(0, 1, 0);
        run(7, 0, 1);

        dsel = 10;
        @(negedge clk) start = 1;
        @(posedge clk) #1 start = 0;
        repeat (4) @(posedge clk);
        #2 rst = 1;
        #1;
        model_reset();
        check("arst_launch", {31'd0, launch}, 0);
        check("arst_busy", {31'd0, busy}, 0);
        check("arst_pulses", {30'd0, done, timeout}, 0);
        check("arst_err", {31'd0, err}, 0);
        check("arst_delay", {16'd0, delay_cnt}, 0);
        check("arst_stats", {min_cnt, max_cnt}, 32'hFFFF0000);
        check("arst_meas", {24'd0, meas_cnt}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        repeat (40) @(posedge clk);
        run(0, 0, 0);

        for (int i = 0; i < 258; i++) run($urandom_range(0, 3), 0, 0);

        for (int i = 0; i < 120; i++) begin
            int d = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - SYNC - 1, TO - SYNC + 2) : $urandom_range(0, 15);
            run(d, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        end

        check("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
